// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: widths, requester ids and Gray-pointer helpers
// used by both the write-side arbiter and the read-side logic.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;
  localparam int PTR_W       = FIFO_ADDR_W + 1;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_id_e;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ {1'b0, bin[PTR_W-1:1]};
  endfunction

  // Full when the pointers differ by exactly one lap: top two Gray bits inverted, rest equal.
  function automatic logic ptr_full(input logic [PTR_W-1:0] wgray,
                                    input logic [PTR_W-1:0] rgray);
    return wgray == {~rgray[PTR_W-1:PTR_W-2], rgray[PTR_W-3:0]};
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for Gray-coded pointers crossing into the g_clk domain.
module ptr_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             g_clk,
  input  logic             w_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] q_r;

  // Metastability settling stage followed by the stable output stage.
  always_ff @(posedge g_clk or negedge w_rst) begin
    if (!w_rst) begin
      meta_r <= {WIDTH{1'b0}};
      q_r    <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: round-robin share of the RAM write
// port between two producers, write pointer ownership and the registered full flag.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W,
  parameter int ADDR_WIDTH = FIFO_ADDR_W
) (
  input  logic                  g_clk,
  input  logic                  w_rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull
);

  logic [PTR_W-1:0]      wbin_r;
  logic [PTR_W-1:0]      wgray_r;
  logic [PTR_W-1:0]      wbin_next_s;
  logic [PTR_W-1:0]      rq2_s;
  req_id_e               last_r;
  logic                  wfull_r;
  logic                  wclken_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [DATA_WIDTH-1:0] wrdata_r;
  logic                  elig0_s;
  logic                  elig1_s;
  logic                  accept_s;

  ptr_sync_2ff #(.WIDTH(PTR_W)) u_rptr_sync (
    .g_clk (g_clk),
    .w_rst (w_rst),
    .d     (rptr_gray),
    .q     (rq2_s)
  );

  // Grants depend only on registered state and the live requests; reset masks them.
  always_comb begin
    elig0_s = req0 & ~wfull_r;
    elig1_s = req1 & ~wfull_r;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!w_rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (elig0_s && elig1_s) begin
      gnt0 = (last_r == REQ_1);
      gnt1 = (last_r == REQ_0);
    end else begin
      gnt0 = elig0_s;
      gnt1 = elig1_s;
    end
    accept_s    = gnt0 | gnt1;
    wbin_next_s = wbin_r + {{(PTR_W-1){1'b0}}, accept_s};
  end

  // Pointer, full flag and RAM write-port registers; full is re-evaluated every edge.
  always_ff @(posedge g_clk or negedge w_rst) begin
    if (!w_rst) begin
      wbin_r   <= {PTR_W{1'b0}};
      wgray_r  <= {PTR_W{1'b0}};
      wfull_r  <= 1'b0;
      wclken_r <= 1'b0;
      waddr_r  <= {ADDR_WIDTH{1'b0}};
      wrdata_r <= {DATA_WIDTH{1'b0}};
      last_r   <= REQ_1;
    end else begin
      wbin_r   <= wbin_next_s;
      wgray_r  <= bin2gray(wbin_next_s);
      wfull_r  <= ptr_full(bin2gray(wbin_next_s), rq2_s);
      wclken_r <= accept_s;
      if (accept_s) begin
        waddr_r  <= wbin_r[ADDR_WIDTH-1:0];
        wrdata_r <= gnt1 ? data1 : data0;
        last_r   <= gnt1 ? REQ_1 : REQ_0;
      end else begin
        waddr_r  <= waddr_r;
        wrdata_r <= wrdata_r;
        last_r   <= last_r;
      end
    end
  end

  assign wclken    = wclken_r;
  assign waddr     = waddr_r;
  assign wrdata    = wrdata_r;
  assign wptr_gray = wgray_r;
  assign wfull     = wfull_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: table vectors, directed corner
// sequences and random traffic against an occupancy-based reference model.
module tb_fifo_wr_arbiter;

  logic       g_clk = 1'b0;
  logic       w_rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1;
  logic [4:0] rptr_gray;
  logic       wclken;
  logic [3:0] waddr;
  logic [7:0] wrdata;
  logic [4:0] wptr_gray;
  logic       wfull;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         m_wbin;
  bit         m_last;
  bit         m_full;
  bit         m_wclken;
  int         m_waddr;
  int         m_wrdata;
  logic [4:0] p1, p2;
  bit         s_gnt0, s_gnt1;

  typedef struct {
    bit         r0, r1;
    logic [7:0] d0, d1;
    bit         g0, g1, en;
    logic [3:0] addr;
    logic [7:0] wd;
  } vec_t;
  vec_t tbl[5];

  fifo_wr_arbiter dut (
    .g_clk     (g_clk),
    .w_rst     (w_rst),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rptr_gray (rptr_gray),
    .wclken    (wclken),
    .waddr     (waddr),
    .wrdata    (wrdata),
    .wptr_gray (wptr_gray),
    .wfull     (wfull)
  );

  always #5 g_clk = ~g_clk;

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    int acc = 0;
    for (int i = 4; i >= 0; i--) begin
      acc = acc ^ ((g >> i) & 1);
      b = b | (acc << i);
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wbin = 0; m_last = 1'b1; m_full = 1'b0; m_wclken = 1'b0;
    m_waddr = 0; m_wrdata = 0; p1 = 5'd0; p2 = 5'd0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_wclken", wclken, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_wptr_gray", wptr_gray, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
  endtask

  // Called at posedge+1: asserts reset between edges, checks, releases after an edge.
  task automatic do_reset();
    #2 w_rst = 1'b0;
    #1 check_reset_outputs();
    @(posedge g_clk);
    #1 w_rst = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check grants mid-cycle, advance model, check registered outputs.
  task automatic cycle(input bit r0, input bit r1, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [4:0] rp);
    bit e0, e1;
    logic [4:0] used;
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; rptr_gray = rp;
    e0 = r0 && !m_full && (!r1 || m_last);
    e1 = r1 && !m_full && (!r0 || !m_last);
    @(negedge g_clk);
    s_gnt0 = gnt0;
    s_gnt1 = gnt1;
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    @(posedge g_clk);
    used = p2; p2 = p1; p1 = rp;
    m_wclken = e0 || e1;
    if (e0 || e1) begin
      m_waddr  = m_wbin & 15;
      m_wrdata = e0 ? d0 : d1;
      m_wbin   = (m_wbin + 1) & 31;
      m_last   = e1;
    end
    m_full = (((m_wbin - g2b(used)) & 31) == 16);
    #1;
    chk("wclken", wclken, m_wclken);
    chk("waddr", waddr, m_waddr);
    chk("wrdata", wrdata, m_wrdata);
    chk("wptr_gray", wptr_gray, b2g(m_wbin));
    chk("wfull", wfull, m_full);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int ngr, full_at, g16_at, fell, tog, wraps, bad1, fulls, rbin, occ;
    logic [4:0] prevg, rp;
    logic [3:0] preva;
    bit r0, r1;

    tbl[0] = '{1'b1, 1'b1, 8'hA0, 8'hB1, 1'b1, 1'b0, 1'b1, 4'd0, 8'hA0};
    tbl[1] = '{1'b1, 1'b1, 8'hA0, 8'hB1, 1'b0, 1'b1, 1'b1, 4'd1, 8'hB1};
    tbl[2] = '{1'b1, 1'b1, 8'hA0, 8'hB1, 1'b1, 1'b0, 1'b1, 4'd2, 8'hA0};
    tbl[3] = '{1'b1, 1'b1, 8'hA0, 8'hB1, 1'b0, 1'b1, 1'b1, 4'd3, 8'hB1};
    tbl[4] = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 4'd3, 8'hB1};

    w_rst = 1'b0; req0 = 1'b1; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00; rptr_gray = 5'd0;
    repeat (2) @(posedge g_clk);
    #1 check_reset_outputs();
    w_rst = 1'b1;
    model_reset();

    // round-robin table
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, 5'd0);
      chk("tbl_gnt0", s_gnt0, tbl[i].g0);
      chk("tbl_gnt1", s_gnt1, tbl[i].g1);
      chk("tbl_wclken", wclken, tbl[i].en);
      chk("tbl_waddr", waddr, tbl[i].addr);
      chk("tbl_wrdata", wrdata, tbl[i].wd);
    end

    // mid-stream reset with req0 held, then first grant goes to requester 0 at address 0
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h30 + 8'(i), 8'h00, 5'd0);
    do_reset();
    cycle(1'b1, 1'b1, 8'h5A, 8'hC3, 5'd0);
    chk("post_rst_gnt0", s_gnt0, 1);
    chk("post_rst_waddr", waddr, 0);
    chk("post_rst_wrdata", wrdata, 8'h5A);

    // fill
    do_reset();
    ngr = 0; full_at = -1; g16_at = -2;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 8'h00, 5'd0);
      if (s_gnt0) begin
        ngr++;
        if (ngr == 16) g16_at = i;
      end
      if (wfull === 1'b1 && full_at < 0) full_at = i;
    end
    chk("fill_grants", ngr, 16);
    chk("fill_full_edge", full_at, g16_at);
    chk("fill_wptr_gray", wptr_gray, 5'h18);
    chk("fill_wfull", wfull, 1);

    // drain release
    fell = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1, 1'b0, 8'h55, 8'h00, 5'h01);
      if (wfull === 1'b0) begin
        fell = k;
        break;
      end
    end
    chk("drain_latency_ok", (fell >= 1 && fell <= 3), 1);
    cycle(1'b1, 1'b0, 8'h66, 8'h00, 5'h01);
    chk("drain_gnt0", s_gnt0, 1);
    chk("drain_waddr", waddr, 0);
    chk("drain_wrdata", wrdata, 8'h66);

    // idle hold
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'hEE, 8'hDD, 5'h01);
    chk("idle_wclken", wclken, 0);
    chk("idle_waddr", waddr, 0);
    chk("idle_wrdata", wrdata, 8'h66);
    chk("idle_wptr_gray", wptr_gray, b2g(17));

    // wrap with reader trailing two behind
    do_reset();
    tog = 0; wraps = 0; bad1 = 0; fulls = 0; prevg = 5'd0; preva = 4'd0;
    for (int i = 0; i < 40; i++) begin
      rp = 5'(b2g((m_wbin - 2) & 31));
      cycle(1'b1, 1'b0, 8'(i), 8'h00, rp);
      if (wptr_gray[4] != prevg[4]) tog++;
      if ($countones(wptr_gray ^ prevg) > 1) bad1++;
      if (i > 0 && preva == 4'd15 && waddr == 4'd0) wraps++;
      if (wfull !== 1'b0) fulls++;
      prevg = wptr_gray;
      preva = waddr;
    end
    chk("wrap_msb_toggles", tog, 2);
    chk("wrap_addr_wraps", wraps, 2);
    chk("wrap_onebit", bad1, 0);
    chk("wrap_no_full", fulls, 0);
    chk("wrap_wptr_gray", wptr_gray, b2g(40 & 31));

    // random traffic with a slowly draining reader
    do_reset();
    rbin = 0;
    for (int i = 0; i < 400; i++) begin
      occ = (m_wbin - rbin) & 31;
      if (occ > 0 && $urandom_range(0, 2) == 0) rbin = (rbin + 1) & 31;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      cycle(r0, r1, 8'($urandom), 8'($urandom), 5'(b2g(rbin)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
